dmem_access_ctrl: RTL and testbench
===================================

# dmem_access_ctrl

Sequences data-memory accesses for the instruction held in the MEM pipeline stage register. It decodes the load/store, drives a request/grant/response handshake to data memory, and asserts `Stall` to the stage registers until the access completes. It also aligns and extends load data for write-back and flags misaligned accesses. It sits between the MEM stage register outputs (`inst`, `alu_out`, `rs2_rdata`) and the data-memory port.

## Interface
- `addrWidth`, 15, byte-address width of data memory.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous reset, active-low.
- `inst` in 32: instruction in the MEM stage.
- `alu_out` in 32: effective byte address.
- `rs2_rdata` in 32: store data.
- `kill` in 1: MEM instruction is squashed; an access is never started while it is high.
- `Stall` out 1: freeze all stage registers.
- `mem_req` out 1: request valid.
- `mem_gnt` in 1: memory accepts the request this cycle.
- `mem_we` out 1: 1 = store.
- `mem_addr` out addrWidth: word-aligned byte address.
- `mem_wstrb` out 4: byte enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_rvalid` in 1: read data valid.
- `mem_rdata` in 32: read word.
- `load_data` out 32: aligned and extended load result.
- `load_valid` out 1: one-cycle pulse when `load_data` is updated.
- `misalign` out 1: one-cycle pulse for a misaligned access.

## Operation
- Decode:
  - Load when `inst[6:0]`=7'b0000011; store when `inst[6:0]`=7'b0100011.
  - Size from `funct3` (`inst[14:12]`): 000 B, 001 H, 010 W, 100 BU, 101 HU. Stores use only 000/001/010.
  - Any other funct3 is treated as no memory operation.
- Misaligned when H/HU and `alu_out[0]`=1, or W and `alu_out[1:0]`≠0.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: if there is a memory op, `kill`=0, and the address is aligned:
    - latch `mem_we`, `mem_addr`={`alu_out[addrWidth-1:2]`,2'b00}, `mem_wstrb`, `mem_wdata`, size, and `alu_out[1:0]`;
    - go to REQ.
  - IDLE, misaligned op with `kill`=0: pulse `misalign`, stay in IDLE, no request, no stall.
  - REQ: hold `mem_req`=1 with the latched fields stable until `mem_gnt`. On grant, a store goes to DONE and a load goes to WAIT.
  - WAIT: on `mem_rvalid`, capture the aligned/extended data into `load_data` and go to DONE. `mem_rvalid` arriving in REQ is ignored.
  - DONE: unconditionally return to IDLE. `load_valid`=1 if the access was a load.
- `Stall` = (IDLE and a starting access) or REQ or WAIT. `Stall` is 0 in DONE so the pipeline advances exactly once per access.
- Store formatting:
  - B: `mem_wstrb`=4'b0001<<off, `mem_wdata`={4{rs2[7:0]}}.
  - H: `mem_wstrb`=4'b0011<<off, `mem_wdata`={2{rs2[15:0]}}.
  - W: `mem_wstrb`=4'b1111, `mem_wdata`=rs2.
  - For loads, `mem_wstrb`=0.
- Load formatting: shift `mem_rdata` right by 8×off, then sign-extend (B, H) or zero-extend (BU, HU).
- `load_data` holds its value until the next load completes.

## Timing
- Reset values: state IDLE, and `Stall`, `mem_req`, `mem_we`, `mem_addr`, `mem_wstrb`, `mem_wdata`, `load_data`, `load_valid`, `misalign` all 0.
- Store with immediate grant: `Stall` is high for 2 cycles (IDLE, REQ); DONE on the 3rd cycle.
- Load with immediate grant and `mem_rvalid` the next cycle: `Stall` is high for 3 cycles; `load_valid` on the 4th cycle.
- Each grant or response delay cycle adds one stall cycle. There is no timeout.
- Back-to-back accesses: the next access starts in the IDLE cycle after DONE, so there is no dead cycle beyond DONE.
- `kill` is sampled only in IDLE. `kill` asserted in REQ or WAIT does not abort; the access completes.
- Reset mid-access: the FSM returns to IDLE and `mem_req` drops immediately (asynchronous). No `load_valid` is produced.
- `misalign` and `load_valid` are never high in the same cycle.

## Test plan
- SW x, `alu_out`=0x100, rs2=0xDEADBEEF, `mem_gnt` immediate:
  - `mem_req`=1 for one cycle with `mem_addr`=0x100, `mem_wstrb`=4'hF, `mem_wdata`=0xDEADBEEF, `mem_we`=1;
  - `Stall` high for 2 cycles.
- LB, `alu_out`=0x103, `mem_rdata`=0x80FF_0000, `mem_gnt` delayed 2 cycles, `mem_rvalid` 1 cycle later:
  - `load_data`=0xFFFFFF80, `load_valid` pulses once;
  - `Stall` high for 5 cycles.
- LHU at 0x102, `mem_rdata`=0xBEEF1234 → `load_data`=0x0000BEEF. SH at 0x102 with rs2=0x5678 → `mem_wstrb`=4'b1100, `mem_wdata`=0x56785678.
- LW at 0x101 → `misalign` pulses, `mem_req`=0, `Stall`=0. The same op with `kill`=1 produces no pulse.
- Two consecutive SB instructions with immediate grant → 2 distinct requests, and the pipeline advances exactly twice.
- Assert `rst_n`=0 during WAIT → `mem_req` and `Stall` go to 0 immediately, `load_data`=0; after release the FSM is in IDLE.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: 2-cycle store / 3-cycle load minimum, Stall held while the access is open.
// Backpressure: each cycle without mem_gnt (REQ) or mem_rvalid (WAIT) adds one Stall cycle; no timeout.
module dmem_access_ctrl #(
  parameter int addrWidth = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          inst,
  input  logic [31:0]          alu_out,
  input  logic [31:0]          rs2_rdata,
  input  logic                 kill,
  output logic                 Stall,
  output logic                 mem_req,
  input  logic                 mem_gnt,
  output logic                 mem_we,
  output logic [addrWidth-1:0] mem_addr,
  output logic [3:0]           mem_wstrb,
  output logic [31:0]          mem_wdata,
  input  logic                 mem_rvalid,
  input  logic [31:0]          mem_rdata,
  output logic [31:0]          load_data,
  output logic                 load_valid,
  output logic                 misalign
);

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state;
  logic [2:0]  size_q;
  logic [1:0]  off_q;
  logic [2:0]  funct3;
  logic        is_load;
  logic        is_store;
  logic        mem_op;
  logic        misaligned;
  logic        start;
  logic [3:0]  wstrb_nxt;
  logic [31:0] wdata_nxt;
  logic [31:0] rdata_shift;
  logic [31:0] load_fmt;
  logic        unused_bits;

  assign funct3   = inst[14:12];
  assign is_load  = (inst[6:0] == OPC_LOAD) &&
                    (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign is_store = (inst[6:0] == OPC_STORE) &&
                    (funct3 inside {3'b000, 3'b001, 3'b010});
  assign mem_op   = is_load | is_store;

  assign misaligned = ((funct3[1:0] == 2'b01) && alu_out[0]) ||
                      ((funct3 == 3'b010) && (alu_out[1:0] != 2'b00));

  // Gated by rst_n so Stall drops the moment reset is applied, whatever sits in MEM.
  assign start = rst_n && (state == IDLE) && mem_op && !kill && !misaligned;
  assign Stall = start || (state == REQ) || (state == WAIT);

  assign unused_bits = ^{inst[31:15], inst[11:7], alu_out[31:addrWidth]};

  always_comb begin
    wstrb_nxt = 4'b0000;
    wdata_nxt = rs2_rdata;
    case (funct3[1:0])
      2'b00: begin
        wdata_nxt = {4{rs2_rdata[7:0]}};
        if (is_store) wstrb_nxt = 4'b0001 << alu_out[1:0];
      end
      2'b01: begin
        wdata_nxt = {2{rs2_rdata[15:0]}};
        if (is_store) wstrb_nxt = 4'b0011 << alu_out[1:0];
      end
      default: begin
        if (is_store) wstrb_nxt = 4'b1111;
      end
    endcase
  end

  assign rdata_shift = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    load_fmt = rdata_shift;
    case (size_q)
      3'b000:  load_fmt = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
      3'b001:  load_fmt = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
      3'b100:  load_fmt = {24'h0, rdata_shift[7:0]};
      3'b101:  load_fmt = {16'h0, rdata_shift[15:0]};
      default: load_fmt = rdata_shift;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wstrb  <= 4'b0000;
      mem_wdata  <= 32'h0;
      size_q     <= 3'b000;
      off_q      <= 2'b00;
      load_data  <= 32'h0;
      load_valid <= 1'b0;
      misalign   <= 1'b0;
    end else begin
      load_valid <= 1'b0;
      misalign   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= REQ;
            mem_req   <= 1'b1;
            mem_we    <= is_store;
            mem_addr  <= {alu_out[addrWidth-1:2], 2'b00};
            mem_wstrb <= wstrb_nxt;
            mem_wdata <= wdata_nxt;
            size_q    <= funct3;
            off_q     <= alu_out[1:0];
          end else if (mem_op && !kill && misaligned) begin
            misalign <= 1'b1;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= mem_we ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            load_data  <= load_fmt;
            load_valid <= 1'b1;
            state      <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: driver pushes expectations from a byte-level model, monitor checks outputs.
module tb_dmem_access_ctrl;

  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   inst;
  logic [31:0]   alu_out;
  logic [31:0]   rs2_rdata;
  logic          kill;
  logic          Stall;
  logic          mem_req;
  logic          mem_gnt;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_wstrb;
  logic [31:0]   mem_wdata;
  logic          mem_rvalid;
  logic [31:0]   mem_rdata;
  logic [31:0]   load_data;
  logic          load_valid;
  logic          misalign;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.addrWidth(AW)) dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .alu_out(alu_out), .rs2_rdata(rs2_rdata),
    .kill(kill), .Stall(Stall), .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .load_data(load_data),
    .load_valid(load_valid), .misalign(misalign)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    bit          chk_wdata;
  } req_t;

  req_t        req_q[$];
  logic [31:0] ld_q[$];
  int          stall_q[$];
  int          mis_pend = 0;
  int          run = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a request, load result, misalign pulse or stall run.
  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0;
    end else begin
      if (mem_req) begin
        chk("req_pending", 32'(req_q.size() != 0), 1);
        if (req_q.size() != 0) begin
          chk("req_we", 32'(mem_we), 32'(req_q[0].we));
          chk("req_addr", 32'(mem_addr), req_q[0].addr);
          chk("req_wstrb", 32'(mem_wstrb), 32'(req_q[0].wstrb));
          if (req_q[0].chk_wdata) chk("req_wdata", mem_wdata, req_q[0].wdata);
          if (mem_gnt) void'(req_q.pop_front());
        end
      end
      if (load_valid) begin
        chk("ld_pending", 32'(ld_q.size() != 0), 1);
        if (ld_q.size() != 0) chk("load_data", load_data, ld_q.pop_front());
      end
      if (misalign) begin
        chk("mis_pending", 32'(mis_pend > 0), 1);
        if (mis_pend > 0) mis_pend--;
      end
      if (load_valid || misalign) chk("lv_mis_excl", 32'(load_valid & misalign), 0);
      if (Stall) begin
        run++;
      end else if (run > 0) begin
        chk("stall_pending", 32'(stall_q.size() != 0), 1);
        if (stall_q.size() != 0) chk("stall_len", run, stall_q.pop_front());
        run = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one MEM-stage instruction and plays the memory side with the given delays.
  task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] rs2, input logic kl, input int gd, input int rd,
                       input logic [31:0] rdat, input bit spur);
    logic [31:0] r;
    logic [31:0] v;
    bit          is_ld, is_st, valid, mis, strt;
    int          nb, off;
    req_t        e;
    r = $urandom();
    r[6:0] = opc;
    r[14:12] = f3;
    is_ld = (opc == 7'h03);
    is_st = (opc == 7'h23);
    valid = is_ld ? (f3 != 3'd3 && f3 < 3'd6) : (is_st ? (f3 < 3'd3) : 1'b0);
    nb    = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
    off   = int'(addr[1:0]);
    mis   = valid && ((off % nb) != 0);
    strt  = valid && !kl && !mis;
    inst = r; alu_out = addr; rs2_rdata = rs2; kill = kl;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    if (valid && !kl && mis) mis_pend++;
    if (strt) begin
      e.we        = is_st;
      e.addr      = addr & 32'h7FFC;
      e.wstrb     = is_st ? 4'(((1 << nb) - 1) << off) : 4'h0;
      e.wdata     = (nb == 1) ? rs2[7:0] * 32'h01010101 :
                    ((nb == 2) ? rs2[15:0] * 32'h00010001 : rs2);
      e.chk_wdata = is_st;
      req_q.push_back(e);
      stall_q.push_back(is_st ? 2 + gd : 3 + gd + rd);
      if (is_ld) begin
        v = rdat >> (8 * off);
        if (nb == 1) begin
          v = v & 32'hFF;
          if (!f3[2] && v >= 128) v = v - 256;
        end else if (nb == 2) begin
          v = v & 32'hFFFF;
          if (!f3[2] && v >= 32768) v = v - 65536;
        end
        ld_q.push_back(v);
      end
    end
    #1;
    chk("stall_at_issue", 32'(Stall), 32'(strt));
    chk("req_at_issue", 32'(mem_req), 0);
    tick();
    if (!strt) return;
    repeat (gd) begin
      mem_rvalid = spur; mem_rdata = ~rdat; kill = 1'($urandom_range(0, 1));
      tick();
    end
    mem_gnt = 1'b1; mem_rvalid = spur; mem_rdata = ~rdat;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    if (is_ld) begin
      repeat (rd) begin
        kill = 1'($urandom_range(0, 1));
        tick();
      end
      mem_rvalid = 1'b1; mem_rdata = rdat;
      tick();
      mem_rvalid = 1'b0; mem_rdata = $urandom();
    end
    tick();
  endtask

  initial begin
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [31:0] addr;
    req_t        rr;
    int          k;
    rst_n = 1'b0; inst = 32'h13; alu_out = 0; rs2_rdata = 0; kill = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(Stall), 0);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wstrb", 32'(mem_wstrb), 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_ldata", load_data, 0);
    chk("rst_lvalid", 32'(load_valid), 0);
    chk("rst_misalign", 32'(misalign), 0);
    rst_n = 1'b1;
    tick();

    issue(7'h23, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    issue(7'h03, 3'b000, 32'h103, 0, 0, 2, 0, 32'h80FF0000, 0);
    issue(7'h03, 3'b101, 32'h102, 0, 0, 0, 0, 32'hBEEF1234, 0);
    issue(7'h23, 3'b001, 32'h102, 32'h5678, 0, 0, 0, 0, 0);
    issue(7'h03, 3'b010, 32'h101, 0, 0, 0, 0, 0, 0);
    issue(7'h03, 3'b010, 32'h101, 0, 1, 0, 0, 0, 0);
    issue(7'h23, 3'b000, 32'h040, 32'h000000AB, 0, 0, 0, 0, 0);
    issue(7'h23, 3'b000, 32'h041, 32'h000000CD, 0, 0, 0, 0, 0);
    issue(7'h13, 3'b000, 32'h0, 0, 0, 0, 0, 0, 0);

    // Reset while a load waits for data: nothing may complete and the FSM must restart idle.
    inst = 32'h00002003; alu_out = 32'h200; kill = 0;
    rr.we = 0; rr.addr = 32'h200; rr.wstrb = 4'h0; rr.wdata = 0; rr.chk_wdata = 0;
    req_q.push_back(rr);
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rstw_req", 32'(mem_req), 0);
    chk("rstw_stall", 32'(Stall), 0);
    chk("rstw_ldata", load_data, 0);
    chk("rstw_lvalid", 32'(load_valid), 0);
    inst = 32'h13;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("post_rst_stall", 32'(Stall), 0);
    chk("post_rst_req", 32'(mem_req), 0);
    tick();
    issue(7'h23, 3'b010, 32'h300, 32'h12345678, 0, 1, 0, 0, 0);

    for (int i = 0; i < 250; i++) begin
      k = $urandom_range(0, 9);
      opc = (k < 4) ? 7'h03 : ((k < 8) ? 7'h23 : 7'h33);
      f3 = 3'($urandom_range(0, 7));
      addr = $urandom();
      if ($urandom_range(0, 1) == 1) addr[1:0] = (f3[1:0] == 2'b01) ? {addr[1], 1'b0} : 2'b00;
      issue(opc, f3, addr, $urandom(), 1'($urandom_range(0, 7) == 0),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom(), 1'($urandom_range(0, 1)));
    end

    inst = 32'h13; kill = 0;
    repeat (3) tick();
    chk("req_q_empty", 32'(req_q.size()), 0);
    chk("ld_q_empty", 32'(ld_q.size()), 0);
    chk("stall_q_empty", 32'(stall_q.size()), 0);
    chk("mis_pend_zero", mis_pend, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
